// File: rtl/cpu_hazard_pkg.sv
// ---------------------------------------------------------------------------
// cpu_hazard_pkg
// Shared definitions for the pipeline interlock controller of the 16-bit
// five-stage core.
//   - hz_state_e : interlock FSM state encodings (RUN / FLUSH / MEM_WAIT)
//   - REG_W      : register specifier width
//   - RS_HI/RT_HI: bit positions of the Rs / Rt fields in an instruction word
//   - NOP_INSTR  : instruction word that the pipeline registers load on a
//                  flush or bubble
//   - reg_hit()  : source/destination register match helper
// ---------------------------------------------------------------------------
package cpu_hazard_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_FLUSH    = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_e;

  localparam int REG_W = 3;

  localparam int RS_HI = 10;
  localparam int RS_LO = RS_HI - REG_W + 1;
  localparam int RT_HI = 7;
  localparam int RT_LO = RT_HI - REG_W + 1;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // A source operand only creates a dependency if the instruction really
  // reads it. r0 is an ordinary register here, so a match on r0 also counts.
  function automatic logic reg_hit(input logic             used,
                                   input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] dst);
    return used && (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the pipeline datapath and the interlock controller.
//   Hazard information (datapath -> controller):
//     id_rs, id_rs_used, id_rt, id_rt_used   decode-stage source operands
//     ex_dest, ex_dest_valid, ex_is_load     execute-stage destination info
//     ex_redirect                            taken branch / jump in EX
//     mem_req, mem_ready                     data-memory handshake
//   Pipeline register control (controller -> datapath):
//     pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
//     ex_mem_en, mem_wb_bubble
// Modports: master = pipeline datapath, slave = interlock controller.
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
  import cpu_hazard_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic             id_rs_used;
  logic [REG_W-1:0] id_rt;
  logic             id_rt_used;
  logic [REG_W-1:0] ex_dest;
  logic             ex_dest_valid;
  logic             ex_is_load;
  logic             ex_redirect;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_bubble;
  logic             ex_mem_en;
  logic             mem_wb_bubble;

  modport master (
    output id_rs, id_rs_used, id_rt, id_rt_used,
           ex_dest, ex_dest_valid, ex_is_load, ex_redirect,
           mem_req, mem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
           ex_mem_en, mem_wb_bubble
  );

  modport slave (
    input  id_rs, id_rs_used, id_rt, id_rt_used,
           ex_dest, ex_dest_valid, ex_is_load, ex_redirect,
           mem_req, mem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
           ex_mem_en, mem_wb_bubble
  );

endinterface

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the interlock performance statistics.
//   clk    in   core clock
//   rst_n  in   synchronous reset, active-low
//   inc    in   count this cycle
//   clr    in   synchronous clear, wins over inc
//   count  out  CNT_W  current value, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Clear has priority so software sees a clean zero right after clearing,
  // even if the event being counted is still happening.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Interlock / stall controller for the 16-bit five-stage core. Resolves the
// hazards forwarding cannot: load-use (one bubble), taken redirect from EX
// (multi-cycle IF/ID flush) and data-memory wait states (full freeze).
//   clk          in   core clock
//   rst_n        in   synchronous reset, active-low
//   hz           slave modport of pipeline_hazard_ctrl_if (hazard inputs,
//                pipeline register enables / flushes / bubbles)
//   perf_clr     in   synchronous clear of both performance counters
//   hz_state     out  2      current FSM state (debug)
//   stall_count  out  CNT_W  cycles with pc_en=0 (saturating)
//   flush_count  out  CNT_W  cycles with if_id_flush=1 (saturating)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import cpu_hazard_pkg::*;
#(
  parameter int REDIRECT_PENALTY = 2,
  parameter int CNT_W            = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.slave  hz,
  input  logic                   perf_clr,
  output logic [1:0]             hz_state,
  output logic [CNT_W-1:0]       stall_count,
  output logic [CNT_W-1:0]       flush_count
);

  // fc counts the flush cycles still owed after the redirect cycle itself.
  localparam logic [2:0] FC_INIT = 3'(REDIRECT_PENALTY - 1);

  hz_state_e  state, state_nxt;
  hz_state_e  ret, ret_nxt;
  hz_state_e  eff_state;
  logic [2:0] fc, fc_nxt;

  logic memstall;
  logic load_use;

  logic pc_en;
  logic if_id_en;
  logic if_id_flush;
  logic id_ex_en;
  logic id_ex_bubble;
  logic ex_mem_en;
  logic mem_wb_bubble;

  assign memstall = hz.mem_req & ~hz.mem_ready;

  assign load_use = hz.ex_is_load & hz.ex_dest_valid &
                    (reg_hit(hz.id_rs_used, hz.id_rs, hz.ex_dest) |
                     reg_hit(hz.id_rt_used, hz.id_rt, hz.ex_dest));

  // When the memory wait finishes, the controller behaves as if it were
  // still in the state it was frozen in, so an interrupted flush resumes.
  assign eff_state = (state == HZ_MEM_WAIT) ? ret : state;

  // State register plus flush down-counter and the state to return to after
  // a memory wait.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= HZ_RUN;
      fc    <= '0;
      ret   <= HZ_RUN;
    end else begin
      state <= state_nxt;
      fc    <= fc_nxt;
      ret   <= ret_nxt;
    end
  end

  // Next-state and pipeline control. Priority: reset, memory freeze,
  // redirect, flush in progress, load-use.
  always_comb begin
    state_nxt     = state;
    fc_nxt        = fc;
    ret_nxt       = ret;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;

    if (!rst_n) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (memstall) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
      if (state != HZ_MEM_WAIT) begin
        state_nxt = HZ_MEM_WAIT;
        ret_nxt   = state;
      end
    end else if (hz.ex_redirect) begin
      // PC takes the branch target; the two younger instructions are dead.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      if (REDIRECT_PENALTY > 1) begin
        state_nxt = HZ_FLUSH;
        fc_nxt    = FC_INIT;
      end else begin
        state_nxt = HZ_RUN;
        fc_nxt    = '0;
      end
    end else if (eff_state == HZ_FLUSH) begin
      // Decode holds a flushed NOP, so no load-use check here.
      if_id_flush = 1'b1;
      if (fc <= 3'd1) begin
        fc_nxt    = '0;
        state_nxt = HZ_RUN;
      end else begin
        fc_nxt    = fc - 3'd1;
        state_nxt = HZ_FLUSH;
      end
    end else begin
      state_nxt = HZ_RUN;
      if (load_use) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  assign hz.pc_en         = pc_en;
  assign hz.if_id_en      = if_id_en;
  assign hz.if_id_flush   = if_id_flush;
  assign hz.id_ex_en      = id_ex_en;
  assign hz.id_ex_bubble  = id_ex_bubble;
  assign hz.ex_mem_en     = ex_mem_en;
  assign hz.mem_wb_bubble = mem_wb_bubble;

  assign hz_state = state;

  // Reset cycles force the controls but must not be counted.
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rst_n & ~pc_en),
    .clr   (perf_clr),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rst_n & if_id_flush),
    .clr   (perf_clr),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl (REDIRECT_PENALTY=2, CNT_W=16).
// ctrl packs the pipeline controls as
//   {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble,
//    mem_wb_bubble}
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        perf_clr;
  logic [1:0]  hz_state;
  logic [15:0] stall_count;
  logic [15:0] flush_count;
  logic [6:0]  ctrl;

  int pass_count;
  int check_count;

  localparam logic [6:0] C_IDLE  = 7'b1111_000;
  localparam logic [6:0] C_RESET = 7'b0000_111;
  localparam logic [6:0] C_LOAD  = 7'b0011_010;
  localparam logic [6:0] C_REDIR = 7'b1111_110;
  localparam logic [6:0] C_FLUSH = 7'b1111_100;
  localparam logic [6:0] C_FROZE = 7'b0000_001;

  pipeline_hazard_ctrl_if hif ();

  pipeline_hazard_ctrl #(
    .REDIRECT_PENALTY (2),
    .CNT_W            (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hz          (hif),
    .perf_clr    (perf_clr),
    .hz_state    (hz_state),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  assign ctrl = {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en,
                 hif.if_id_flush, hif.id_ex_bubble, hif.mem_wb_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of hazard inputs and let the combinational outputs settle.
  task automatic applyStimulus(input logic [2:0] rs, input logic rs_used,
                               input logic [2:0] rt, input logic rt_used,
                               input logic [2:0] dest, input logic dest_valid,
                               input logic is_load, input logic redirect,
                               input logic req, input logic ready);
    hif.id_rs         = rs;
    hif.id_rs_used    = rs_used;
    hif.id_rt         = rt;
    hif.id_rt_used    = rt_used;
    hif.ex_dest       = dest;
    hif.ex_dest_valid = dest_valid;
    hif.ex_is_load    = is_load;
    hif.ex_redirect   = redirect;
    hif.mem_req       = req;
    hif.mem_ready     = ready;
    #1;
  endtask

  task automatic idle();
    applyStimulus(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Linear directed sequence; every expected value is worked out by hand.
  initial begin
    pass_count  = 0;
    check_count = 0;
    rst_n       = 1'b0;
    perf_clr    = 1'b0;
    idle();

    // Reset: forced controls while low, clean state after the edge.
    checkOutput("reset_ctrl", 32'(ctrl), 32'(C_RESET));
    tick();
    checkOutput("reset_state", 32'(hz_state), 32'd0);
    checkOutput("reset_stall", 32'(stall_count), 32'd0);
    checkOutput("reset_flush", 32'(flush_count), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("run_idle_ctrl", 32'(ctrl), 32'(C_IDLE));
    tick();
    checkOutput("idle_stall", 32'(stall_count), 32'd0);

    // Load-use on Rs.
    applyStimulus(3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs_ctrl", 32'(ctrl), 32'(C_LOAD));
    tick();
    idle();
    checkOutput("lu_rs_stall", 32'(stall_count), 32'd1);
    checkOutput("lu_rs_after", 32'(ctrl), 32'(C_IDLE));
    checkOutput("lu_rs_state", 32'(hz_state), 32'd0);

    // Load-use on Rt only.
    applyStimulus(3'd2, 1'b0, 3'd5, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rt_ctrl", 32'(ctrl), 32'(C_LOAD));
    tick();
    // r0 match stalls like any other register.
    applyStimulus(3'd0, 1'b1, 3'd1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_r0_ctrl", 32'(ctrl), 32'(C_LOAD));
    tick();
    checkOutput("lu_r0_stall", 32'(stall_count), 32'd3);
    // Not a load: no stall.
    applyStimulus(3'd0, 1'b1, 3'd1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("noload_ctrl", 32'(ctrl), 32'(C_IDLE));
    tick();
    // Register matches but operands are unused: no stall.
    applyStimulus(3'd4, 1'b0, 3'd4, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("unused_ctrl", 32'(ctrl), 32'(C_IDLE));
    tick();
    // Load without a valid destination: no stall.
    applyStimulus(3'd4, 1'b1, 3'd4, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("novalid_ctrl", 32'(ctrl), 32'(C_IDLE));
    tick();
    idle();
    checkOutput("no_stall_cnt", 32'(stall_count), 32'd3);

    // Redirect with default penalty of two flush cycles.
    applyStimulus(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("redir_c0_ctrl", 32'(ctrl), 32'(C_REDIR));
    tick();
    idle();
    checkOutput("redir_c1_state", 32'(hz_state), 32'd1);
    checkOutput("redir_c1_ctrl", 32'(ctrl), 32'(C_FLUSH));
    tick();
    checkOutput("redir_c2_state", 32'(hz_state), 32'd0);
    checkOutput("redir_c2_flush", 32'(flush_count), 32'd2);
    checkOutput("redir_c2_ctrl", 32'(ctrl), 32'(C_IDLE));

    // Clear counters before the memory-wait scenario.
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    checkOutput("clr_stall", 32'(stall_count), 32'd0);
    checkOutput("clr_flush", 32'(flush_count), 32'd0);

    // Memory wait in the middle of a flush.
    applyStimulus(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("mw_enter_ctrl", 32'(ctrl), 32'(C_FROZE));
    tick();
    checkOutput("mw_w1_state", 32'(hz_state), 32'd2);
    checkOutput("mw_w1_ctrl", 32'(ctrl), 32'(C_FROZE));
    tick();
    checkOutput("mw_w2_ctrl", 32'(ctrl), 32'(C_FROZE));
    tick();
    applyStimulus(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mw_ready_ctrl", 32'(ctrl), 32'(C_FLUSH));
    checkOutput("mw_ready_state", 32'(hz_state), 32'd2);
    tick();
    idle();
    checkOutput("mw_done_state", 32'(hz_state), 32'd0);
    checkOutput("mw_done_stall", 32'(stall_count), 32'd3);
    checkOutput("mw_done_flush", 32'(flush_count), 32'd2);

    // Load-use coincident with redirect: redirect wins, no stall.
    applyStimulus(3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("lu_redir_ctrl", 32'(ctrl), 32'(C_REDIR));
    tick();
    idle();
    checkOutput("lu_redir_stall", 32'(stall_count), 32'd3);
    checkOutput("lu_redir_state", 32'(hz_state), 32'd1);
    tick();
    checkOutput("lu_redir_flush", 32'(flush_count), 32'd4);

    // Redirect again while flushing restarts the flush.
    applyStimulus(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("restart_c1_ctrl", 32'(ctrl), 32'(C_REDIR));
    tick();
    idle();
    checkOutput("restart_c2_state", 32'(hz_state), 32'd1);
    tick();
    checkOutput("restart_end_state", 32'(hz_state), 32'd0);
    checkOutput("restart_end_flush", 32'(flush_count), 32'd7);

    // Reset in the middle of a memory wait.
    applyStimulus(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("pre_rst_state", 32'(hz_state), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ctrl", 32'(ctrl), 32'(C_RESET));
    tick();
    checkOutput("mid_rst_state", 32'(hz_state), 32'd0);
    checkOutput("mid_rst_stall", 32'(stall_count), 32'd0);
    checkOutput("mid_rst_flush", 32'(flush_count), 32'd0);
    tick();
    checkOutput("rst_hold_stall", 32'(stall_count), 32'd0);
    rst_n = 1'b1;
    idle();
    checkOutput("post_rst_ctrl", 32'(ctrl), 32'(C_IDLE));

    // Saturation of the stall counter, then clear while still stalling.
    applyStimulus(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (65540) @(posedge clk);
    #1;
    checkOutput("sat_stall", 32'(stall_count), 32'h0000_FFFF);
    checkOutput("sat_flush", 32'(flush_count), 32'd0);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    checkOutput("sat_clr", 32'(stall_count), 32'd0);
    tick();
    checkOutput("sat_after_clr", 32'(stall_count), 32'd1);
    idle();
    checkOutput("sat_release_ctrl", 32'(ctrl), 32'(C_IDLE));
    tick();
    checkOutput("sat_release_state", 32'(hz_state), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
